turn_queue_decoder: RTL and testbench

- Sits between the PS/2 interface (key_data / key_pressed strobe) and the per-bike orientation logic.
- Parses PS/2 scan-code sequences, including the E0 (extended) and F0 (break) prefixes, into make events for the four players' direction keys.
- Holds up to 2 pending turns per bike and releases one per bike on each game step pulse. Quick double-taps are not lost; 180° reversals and duplicates never reach the processor.

---
 rtl/turn_queue_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_turn_queue_decoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_queue_decoder.sv
// PS/2 scan-code parser feeding a small turn queue per player, drained one entry per game step.
// Optional build macro TURN_QUEUE_EXTENDED_STRICT_EN: p4 accepts only extended makes, p1-p3 only plain makes.
module turn_queue_decoder #(
  parameter int DEPTH          = 2,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  key_data,
  input  logic        key_pressed,
  input  logic        enable,
  input  logic        clear,
  input  logic        step,
  output logic [7:0]  heading,
  output logic [3:0]  turn_valid,
  output logic [3:0]  overflow,
  output logic [11:0] pending
);
  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [7:0] HEADING_INIT = 8'b00_01_10_11;
  localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_t;

  parse_state_t  state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          make_valid_reg, make_valid_next;
  logic [7:0]    make_code_reg, make_code_next;
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
  logic          make_ext_reg, make_ext_next;
`endif

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    make_valid_next = 1'b0;
    make_code_next  = make_code_reg;
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
    make_ext_next   = make_ext_reg;
`endif
    if (key_pressed) begin
      timer_next = TW'(PREFIX_TIMEOUT - 1);
      case (state_reg)
        IDLE: begin
          if (key_data == 8'hE0)      state_next = EXT;
          else if (key_data == 8'hF0) state_next = BRK;
          else begin
            make_valid_next = 1'b1;
            make_code_next  = key_data;
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
            make_ext_next   = 1'b0;
`endif
          end
        end
        EXT: begin
          if (key_data == 8'hF0)      state_next = EXT_BRK;
          else if (key_data == 8'hE0) state_next = EXT;
          else begin
            state_next      = IDLE;
            make_valid_next = 1'b1;
            make_code_next  = key_data;
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
            make_ext_next   = 1'b1;
`endif
          end
        end
        default: state_next = IDLE;  // break byte is consumed and discarded
      endcase
    end else if (state_reg != IDLE) begin
      if (timer_reg == '0) state_next = IDLE;
      else                 timer_next = timer_reg - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      make_valid_reg <= 1'b0;
      make_code_reg  <= 8'h00;
    end else if (clear) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      make_valid_reg <= 1'b0;
      make_code_reg  <= 8'h00;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      make_valid_reg <= make_valid_next;
      make_code_reg  <= make_code_next;
    end
  end

`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     make_ext_reg <= 1'b0;
    else if (clear)  make_ext_reg <= 1'b0;
    else             make_ext_reg <= make_ext_next;
  end
`endif

  logic       mapped, push_req;
  logic [1:0] key_player, key_dir;

  always_comb begin
    mapped     = 1'b1;
    key_player = 2'd0;
    key_dir    = DIR_UP;
    case (make_code_reg)
      8'h1C: begin key_player = 2'd0; key_dir = DIR_LEFT;  end
      8'h23: begin key_player = 2'd0; key_dir = DIR_RIGHT; end
      8'h1D: begin key_player = 2'd0; key_dir = DIR_UP;    end
      8'h1B: begin key_player = 2'd0; key_dir = DIR_DOWN;  end
      8'h2B: begin key_player = 2'd1; key_dir = DIR_LEFT;  end
      8'h33: begin key_player = 2'd1; key_dir = DIR_RIGHT; end
      8'h2C: begin key_player = 2'd1; key_dir = DIR_UP;    end
      8'h34: begin key_player = 2'd1; key_dir = DIR_DOWN;  end
      8'h3B: begin key_player = 2'd2; key_dir = DIR_LEFT;  end
      8'h4B: begin key_player = 2'd2; key_dir = DIR_RIGHT; end
      8'h43: begin key_player = 2'd2; key_dir = DIR_UP;    end
      8'h42: begin key_player = 2'd2; key_dir = DIR_DOWN;  end
      8'h6B: begin key_player = 2'd3; key_dir = DIR_LEFT;  end
      8'h74: begin key_player = 2'd3; key_dir = DIR_RIGHT; end
      8'h75: begin key_player = 2'd3; key_dir = DIR_UP;    end
      8'h72: begin key_player = 2'd3; key_dir = DIR_DOWN;  end
      default: mapped = 1'b0;
    endcase
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
    push_req = make_valid_reg && enable && mapped && (make_ext_reg == (key_player == 2'd3));
`else
    push_req = make_valid_reg && enable && mapped;
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_player
      logic [1:0] q_reg [DEPTH];
      logic [1:0] q_next [DEPTH];
      logic [2:0] count_reg, count_next;
      logic [1:0] heading_reg, heading_next;
      logic       turn_reg, turn_next;
      logic       ovf_reg, ovf_next;
      logic [1:0] ref_dir;
      logic       pop, hit;

      // Pop first, then judge the push against the post-pop tail and occupancy.
      always_comb begin
        pop          = step && (count_reg != 3'd0);
        heading_next = pop ? q_reg[0] : heading_reg;
        count_next   = count_reg - {2'b00, pop};
        turn_next    = pop;
        ovf_next     = ovf_reg;
        for (int i = 0; i < DEPTH; i++) q_next[i] = q_reg[i];
        if (pop) begin
          for (int i = 1; i < DEPTH; i++) q_next[i-1] = q_reg[i];
        end
        ref_dir = heading_next;
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(count_next) == i + 1) ref_dir = q_next[i];
        end
        // Same axis bit means duplicate or reversal; only perpendicular turns qualify.
        hit = push_req && (key_player == 2'(gi)) && (key_dir[1] != ref_dir[1]);
        if (hit) begin
          if (int'(count_next) < DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (int'(count_next) == i) q_next[i] = key_dir;
            end
            count_next = count_next + 3'd1;
          end else begin
            ovf_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) q_reg[i] <= 2'b00;
          count_reg   <= 3'd0;
          heading_reg <= HEADING_INIT[2*gi +: 2];
          turn_reg    <= 1'b0;
          ovf_reg     <= 1'b0;
        end else if (clear) begin
          for (int i = 0; i < DEPTH; i++) q_reg[i] <= 2'b00;
          count_reg   <= 3'd0;
          heading_reg <= HEADING_INIT[2*gi +: 2];
          turn_reg    <= 1'b0;
          ovf_reg     <= 1'b0;
        end else begin
          for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
          count_reg   <= count_next;
          heading_reg <= heading_next;
          turn_reg    <= turn_next;
          ovf_reg     <= ovf_next;
        end
      end

      assign heading[2*gi +: 2] = heading_reg;
      assign pending[3*gi +: 3] = count_reg;
      assign turn_valid[gi]     = turn_reg;
      assign overflow[gi]       = ovf_reg;
    end
  endgenerate
endmodule

// File: tb/tb_turn_queue_decoder.sv
// Self-checking bench for turn_queue_decoder: directed scenarios plus randomized key/step traffic
// compared against a queue-based reference model of the turn rules.
`timescale 1ns/1ps
module tb_turn_queue_decoder;
  localparam int DEPTH = 2;
  localparam int TMO   = 16;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_pressed = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  heading;
  logic [3:0]  turn_valid;
  logic [3:0]  overflow;
  logic [11:0] pending;

  int vecs = 0;
  int errs = 0;

  always #50 clock = ~clock;

  turn_queue_decoder #(.DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_pressed(key_pressed),
    .enable(enable), .clear(clear), .step(step), .heading(heading),
    .turn_valid(turn_valid), .overflow(overflow), .pending(pending)
  );

  // Reference model: one SV queue of directions per player.
  logic [1:0] m_hd [4];
  logic [1:0] m_q  [4][$];
  logic [3:0] m_ovf;
  logic [3:0] m_tv;

  function automatic void model_clear();
    m_hd[0] = RIGHT; m_hd[1] = LEFT; m_hd[2] = DOWN; m_hd[3] = UP;
    for (int p = 0; p < 4; p++) m_q[p].delete();
    m_ovf = 4'b0000;
    m_tv  = 4'b0000;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  function automatic bit map_code(input logic [7:0] code, input bit ext, output int p, output logic [1:0] d);
    bit ok;
    ok = 1'b1; p = 0; d = UP;
    case (code)
      8'h1C: begin p = 0; d = LEFT; end   8'h23: begin p = 0; d = RIGHT; end
      8'h1D: begin p = 0; d = UP;   end   8'h1B: begin p = 0; d = DOWN;  end
      8'h2B: begin p = 1; d = LEFT; end   8'h33: begin p = 1; d = RIGHT; end
      8'h2C: begin p = 1; d = UP;   end   8'h34: begin p = 1; d = DOWN;  end
      8'h3B: begin p = 2; d = LEFT; end   8'h4B: begin p = 2; d = RIGHT; end
      8'h43: begin p = 2; d = UP;   end   8'h42: begin p = 2; d = DOWN;  end
      8'h6B: begin p = 3; d = LEFT; end   8'h74: begin p = 3; d = RIGHT; end
      8'h75: begin p = 3; d = UP;   end   8'h72: begin p = 3; d = DOWN;  end
      default: ok = 1'b0;
    endcase
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
    if (ok && (ext != (p == 3))) ok = 1'b0;
`else
    if (ext) ok = ok;
`endif
    return ok;
  endfunction

  function automatic void model_make(input logic [7:0] code, input bit ext);
    int p;
    logic [1:0] d, r;
    if (!enable) return;
    if (!map_code(code, ext, p, d)) return;
    r = (m_q[p].size() > 0) ? m_q[p][$] : m_hd[p];
    if (d == r || d == opposite(r)) return;
    if (m_q[p].size() >= DEPTH) m_ovf[p] = 1'b1;
    else m_q[p].push_back(d);
  endfunction

  function automatic void model_step();
    m_tv = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      if (m_q[p].size() > 0) begin
        m_hd[p] = m_q[p].pop_front();
        m_tv[p] = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] exp_heading();
    return {m_hd[3], m_hd[2], m_hd[1], m_hd[0]};
  endfunction

  function automatic logic [11:0] exp_pending();
    return {3'(m_q[3].size()), 3'(m_q[2].size()), 3'(m_q[1].size()), 3'(m_q[0].size())};
  endfunction

  // Stimulus drivers (every wait is a fixed number of clocks).
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock); key_data = b; key_pressed = 1'b1;
    @(negedge clock); key_pressed = 1'b0;
  endtask

  task automatic key_make(input logic [7:0] code, input bit ext);
    if (ext) send_byte(8'hE0);
    send_byte(code);
    model_make(code, ext);
    m_tv = 4'b0000;
    @(negedge clock);
    $display("tx make %s%h heading=%h pending=%h", ext ? "E0 " : "", code, heading, pending);
  endtask

  task automatic key_break(input logic [7:0] code, input bit ext);
    if (ext) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
    m_tv = 4'b0000;
    @(negedge clock);
    $display("tx break %s%h heading=%h pending=%h", ext ? "E0 " : "", code, heading, pending);
  endtask

  task automatic do_step();
    @(negedge clock); step = 1'b1;
    @(negedge clock); step = 1'b0;
    model_step();
    $display("tx step heading=%h turn_valid=%b pending=%h", heading, turn_valid, pending);
  endtask

  task automatic make_step(input logic [7:0] code, input bit ext);
    if (ext) send_byte(8'hE0);
    @(negedge clock); key_data = code; key_pressed = 1'b1;
    @(negedge clock); key_pressed = 1'b0; step = 1'b1;
    @(negedge clock); step = 1'b0;
    model_step();
    model_make(code, ext);
    $display("tx make+step %h heading=%h turn_valid=%b pending=%h", code, heading, turn_valid, pending);
  endtask

  task automatic do_clear(input bit with_step);
    @(negedge clock); clear = 1'b1; step = with_step;
    @(negedge clock); clear = 1'b0; step = 1'b0;
    model_clear();
    $display("tx clear step=%0d heading=%h pending=%h", with_step, heading, pending);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1;
    model_clear();
    repeat (3) @(negedge clock);
    if (heading !== 8'h1B) begin errs++; $display("FAIL rst_heading got=%h want=1b", heading); end vecs++;
    if (turn_valid !== 4'h0) begin errs++; $display("FAIL rst_turn_valid got=%b want=0000", turn_valid); end vecs++;
    if (overflow !== 4'h0) begin errs++; $display("FAIL rst_overflow got=%b want=0000", overflow); end vecs++;
    if (pending !== 12'h000) begin errs++; $display("FAIL rst_pending got=%h want=000", pending); end vecs++;
    resetn = 1'b1;
    // Reset in the middle of an F0 prefix must leave the parser in IDLE.
    send_byte(8'hF0);
    @(negedge clock); resetn = 1'b0;
    @(negedge clock); resetn = 1'b1;
    key_make(8'h1D, 1'b0);
    if (pending !== 12'h001) begin errs++; $display("FAIL rst_prefix_discard got=%h want=001", pending); end vecs++;
    do_clear(1'b0);
    do_step();
    if (heading !== 8'h1B) begin errs++; $display("FAIL hold_heading got=%h want=1b", heading); end vecs++;
    if (turn_valid !== 4'h0) begin errs++; $display("FAIL hold_turn_valid got=%b want=0000", turn_valid); end vecs++;
    if (pending !== 12'h000) begin errs++; $display("FAIL hold_pending got=%h want=000", pending); end vecs++;
  endtask

  task automatic test_queued_turn();
    key_make(8'h1D, 1'b0);
    if (pending !== 12'h001) begin errs++; $display("FAIL qt_pending got=%h want=001", pending); end vecs++;
    do_step();
    if (heading !== 8'h18) begin errs++; $display("FAIL qt_heading got=%h want=18", heading); end vecs++;
    if (turn_valid !== 4'b0001) begin errs++; $display("FAIL qt_turn_valid got=%b want=0001", turn_valid); end vecs++;
    @(negedge clock);
    if (turn_valid !== 4'b0000) begin errs++; $display("FAIL qt_pulse_len got=%b want=0000", turn_valid); end vecs++;
    key_break(8'h1D, 1'b0);
    if (pending !== 12'h000) begin errs++; $display("FAIL qt_break_pending got=%h want=000", pending); end vecs++;
    if (heading !== 8'h18) begin errs++; $display("FAIL qt_break_heading got=%h want=18", heading); end vecs++;
  endtask

  task automatic test_reversal_dup();
    do_clear(1'b0);
    key_make(8'h1C, 1'b0);
    if (pending !== 12'h000) begin errs++; $display("FAIL rev_pending got=%h want=000", pending); end vecs++;
    key_make(8'h23, 1'b0);
    if (pending !== 12'h000) begin errs++; $display("FAIL dup_pending got=%h want=000", pending); end vecs++;
    if (overflow !== 4'h0) begin errs++; $display("FAIL dup_overflow got=%b want=0000", overflow); end vecs++;
  endtask

  task automatic test_overflow();
    key_make(8'h2C, 1'b0);
    key_make(8'h33, 1'b0);
    key_make(8'h2C, 1'b0);
    if (pending !== 12'h010) begin errs++; $display("FAIL ovf_pending got=%h want=010", pending); end vecs++;
    if (overflow !== 4'b0010) begin errs++; $display("FAIL ovf_flag got=%b want=0010", overflow); end vecs++;
    do_step();
    if (heading[3:2] !== UP) begin errs++; $display("FAIL ovf_step1 got=%b want=00", heading[3:2]); end vecs++;
    do_step();
    if (heading[3:2] !== RIGHT) begin errs++; $display("FAIL ovf_step2 got=%b want=11", heading[3:2]); end vecs++;
    if (overflow !== 4'b0010) begin errs++; $display("FAIL ovf_sticky got=%b want=0010", overflow); end vecs++;
  endtask

  task automatic test_extended();
    logic [11:0] want;
    do_clear(1'b0);
    key_make(8'h74, 1'b1);
    if (pending !== 12'h200) begin errs++; $display("FAIL ext_p4 got=%h want=200", pending); end vecs++;
    key_make(8'h75, 1'b0);
    key_make(8'h1D, 1'b1);
`ifdef TURN_QUEUE_EXTENDED_STRICT_EN
    want = 12'h200;
`else
    want = 12'h401;
`endif
    if (pending !== want) begin errs++; $display("FAIL ext_plain got=%h want=%h", pending, want); end vecs++;
    if (pending !== exp_pending()) begin errs++; $display("FAIL ext_model got=%h want=%h", pending, exp_pending()); end vecs++;
  endtask

  task automatic test_timeout_clear();
    do_clear(1'b0);
    send_byte(8'hE0);
    repeat (TMO + 1) @(negedge clock);
    send_byte(8'h1D);
    model_make(8'h1D, 1'b0);
    @(negedge clock);
    if (pending !== 12'h001) begin errs++; $display("FAIL tmo_ext got=%h want=001", pending); end vecs++;
    send_byte(8'hF0);
    repeat (TMO / 2) @(negedge clock);
    send_byte(8'h1C);
    @(negedge clock);
    if (pending !== 12'h001) begin errs++; $display("FAIL tmo_early got=%h want=001", pending); end vecs++;
    send_byte(8'hF0);
    repeat (TMO + 1) @(negedge clock);
    send_byte(8'h1C);
    model_make(8'h1C, 1'b0);
    @(negedge clock);
    if (pending !== 12'h002) begin errs++; $display("FAIL tmo_brk got=%h want=002", pending); end vecs++;
    key_make(8'h2C, 1'b0);
    key_make(8'h33, 1'b0);
    key_make(8'h2C, 1'b0);
    do_clear(1'b1);
    if (heading !== 8'h1B) begin errs++; $display("FAIL clr_heading got=%h want=1b", heading); end vecs++;
    if (turn_valid !== 4'h0) begin errs++; $display("FAIL clr_turn_valid got=%b want=0000", turn_valid); end vecs++;
    if (overflow !== 4'h0) begin errs++; $display("FAIL clr_overflow got=%b want=0000", overflow); end vecs++;
    if (pending !== 12'h000) begin errs++; $display("FAIL clr_pending got=%h want=000", pending); end vecs++;
  endtask

  task automatic test_back_to_back();
    do_clear(1'b0);
    key_make(8'h1D, 1'b0);
    make_step(8'h1C, 1'b0);
    if (heading[1:0] !== UP) begin errs++; $display("FAIL b2b_heading got=%b want=00", heading[1:0]); end vecs++;
    if (turn_valid !== 4'b0001) begin errs++; $display("FAIL b2b_turn_valid got=%b want=0001", turn_valid); end vecs++;
    if (pending !== 12'h001) begin errs++; $display("FAIL b2b_pending got=%h want=001", pending); end vecs++;
    key_make(8'h2C, 1'b0);
    key_make(8'h33, 1'b0);
    make_step(8'h2C, 1'b0);
    if (heading !== 8'h12) begin errs++; $display("FAIL full_step_heading got=%h want=12", heading); end vecs++;
    if (turn_valid !== 4'b0011) begin errs++; $display("FAIL full_step_tv got=%b want=0011", turn_valid); end vecs++;
    if (pending !== 12'h010) begin errs++; $display("FAIL full_step_pending got=%h want=010", pending); end vecs++;
    if (overflow !== 4'h0) begin errs++; $display("FAIL full_step_ovf got=%b want=0000", overflow); end vecs++;
    enable = 1'b0;
    key_make(8'h3B, 1'b0);
    do_step();
    if (pending !== 12'h008) begin errs++; $display("FAIL dis_pending got=%h want=008", pending); end vecs++;
    if (heading[3:2] !== RIGHT) begin errs++; $display("FAIL dis_drain got=%b want=11", heading[3:2]); end vecs++;
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] codes [18];
    logic [7:0] c;
    bit e;
    int op;
    codes = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2B, 8'h33, 8'h2C, 8'h34,
              8'h3B, 8'h4B, 8'h43, 8'h42, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A};
    do_clear(1'b0);
    for (int n = 0; n < 250; n++) begin
      c  = codes[$urandom_range(0, 17)];
      e  = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 19);
      if (op < 9)       key_make(c, e);
      else if (op < 11) key_break(c, e);
      else if (op < 15) do_step();
      else if (op < 18) make_step(c, e);
      else if (op < 19) enable = ($urandom_range(0, 3) != 0);
      else              do_clear($urandom_range(0, 1) == 1);
      if (heading !== exp_heading()) begin errs++; $display("FAIL rnd%0d_heading got=%h want=%h", n, heading, exp_heading()); end vecs++;
      if (turn_valid !== m_tv) begin errs++; $display("FAIL rnd%0d_turn_valid got=%b want=%b", n, turn_valid, m_tv); end vecs++;
      if (pending !== exp_pending()) begin errs++; $display("FAIL rnd%0d_pending got=%h want=%h", n, pending, exp_pending()); end vecs++;
      if (overflow !== m_ovf) begin errs++; $display("FAIL rnd%0d_overflow got=%b want=%b", n, overflow, m_ovf); end vecs++;
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_queued_turn();
    test_reversal_dup();
    test_overflow();
    test_extended();
    test_timeout_clear();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
